tail_cmd_conditioner: RTL and testbench

Input conditioning stage placed directly upstream of the tail-light sequencer. Raw driver controls are the turn stalk, brake switch, hazard button and fog button. The block synchronises and debounces each control and turns the momentary buttons into latched toggles. It delivers clean level commands `left`, `right`, `brake`, `alarm` and `fog` to the sequencer. All outputs are registered, so the sequencer sees only stable, single-cycle-aligned changes.

---
 rtl/tail_light_pkg.sv | 18 +
 rtl/debounce_ch.sv | 64 ++++++
 rtl/tail_cmd_conditioner.sv | 115 +++++++++++
 tb/tb_tail_cmd_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light input conditioner and sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tail_light_pkg;

    // Channel order of the raw driver controls inside the conditioner.
    typedef enum logic [2:0] {
        CH_L   = 3'd0,
        CH_R   = 3'd1,
        CH_B   = 3'd2,
        CH_HAZ = 3'd3,
        CH_FOG = 3'd4
    } ch_e;

    localparam int N_CH           = 5;
    localparam int DEB_CYCLES_DEF = 3;

endpackage

// File: rtl/debounce_ch.sv
// One control channel: 2-flop synchroniser, mismatch counter and debounced level.
// Latency: stable_o flips DEB_CYCLES+2 edges after the raw change is first sampled.
// Backpressure: none; free-running every cycle.
module debounce_ch #(
    parameter int DEB_CYCLES = 3,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic s2_o,
    output logic s2_vld_o
);

    logic             s1_q, s2_q;
    logic             v1_q, v2_q;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce decision: a mismatch must persist DEB_CYCLES cycles to flip stable.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = stable_d & ~stable_q;
    end

    // Sync stages, a valid tag that tells when s2 holds a real sample, and debounce state.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            v1_q     <= 1'b1;
            v2_q     <= v1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign s2_o     = s2_q;
    assign s2_vld_o = v2_q;

endmodule

// File: rtl/tail_cmd_conditioner.sv
// Conditions raw stalk/brake/button inputs into clean registered commands for the sequencer.
// Latency: output changes DEB_CYCLES+3 edges after a raw change is first sampled.
// Backpressure: none; levels are presented every cycle, cmd_upd flags changes.
module tail_cmd_conditioner
    import tail_light_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic brake_sw,
    input  logic hazard_btn,
    input  logic fog_btn,
    output logic left,
    output logic right,
    output logic brake,
    output logic alarm,
    output logic fog,
    output logic stalk_fault,
    output logic cmd_upd
);

    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] s2;
    logic [N_CH-1:0] s2_vld;

    assign raw[CH_L]   = left_sw;
    assign raw[CH_R]   = right_sw;
    assign raw[CH_B]   = brake_sw;
    assign raw[CH_HAZ] = hazard_btn;
    assign raw[CH_FOG] = fog_btn;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (raw[g]),
            .stable_o (stable[g]),
            .rise_o   (rise[g]),
            .s2_o     (s2[g]),
            .s2_vld_o (s2_vld[g])
        );
    end

    logic left_q, left_d;
    logic right_q, right_d;
    logic brake_q, brake_d;
    logic alarm_q, alarm_d;
    logic fog_q, fog_d;
    logic fault_q, fault_d;
    logic upd_q, upd_d;
    logic haz_armed_q, haz_armed_d;
    logic fog_armed_q, fog_armed_d;

    // Stalk decode, button arming and toggles, and change detection for cmd_upd.
    // A button arms only once a real released sample has been seen, so a button
    // held through reset cannot produce a toggle when it first qualifies.
    always_comb begin
        left_d  = stable[CH_L] & ~stable[CH_R];
        right_d = stable[CH_R] & ~stable[CH_L];
        fault_d = stable[CH_L] & stable[CH_R];
        brake_d = stable[CH_B];

        haz_armed_d = haz_armed_q | (s2_vld[CH_HAZ] & ~s2[CH_HAZ] & ~stable[CH_HAZ]);
        fog_armed_d = fog_armed_q | (s2_vld[CH_FOG] & ~s2[CH_FOG] & ~stable[CH_FOG]);

        alarm_d = alarm_q ^ (rise[CH_HAZ] & haz_armed_q);
        fog_d   = fog_q   ^ (rise[CH_FOG] & fog_armed_q);

        upd_d = ({left_d, right_d, brake_d, alarm_d, fog_d} !=
                 {left_q, right_q, brake_q, alarm_q, fog_q});
    end

    // Output and arming registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            brake_q     <= 1'b0;
            alarm_q     <= 1'b0;
            fog_q       <= 1'b0;
            fault_q     <= 1'b0;
            upd_q       <= 1'b0;
            haz_armed_q <= 1'b0;
            fog_armed_q <= 1'b0;
        end else begin
            left_q      <= left_d;
            right_q     <= right_d;
            brake_q     <= brake_d;
            alarm_q     <= alarm_d;
            fog_q       <= fog_d;
            fault_q     <= fault_d;
            upd_q       <= upd_d;
            haz_armed_q <= haz_armed_d;
            fog_armed_q <= fog_armed_d;
        end
    end

    assign left        = left_q;
    assign right       = right_q;
    assign brake       = brake_q;
    assign alarm       = alarm_q;
    assign fog         = fog_q;
    assign stalk_fault = fault_q;
    assign cmd_upd     = upd_q;

endmodule

// File: tb/tb_tail_cmd_conditioner.sv
// Scoreboard bench for tail_cmd_conditioner with DEB_CYCLES=3.
// Expectations are queued with the edge number at which they must be visible.
// A negedge monitor pops and compares them.
module tb_tail_cmd_conditioner;

    // Output vector order: {left, right, brake, alarm, fog, stalk_fault, cmd_upd}
    localparam logic [6:0] O_L  = 7'b1000000;
    localparam logic [6:0] O_R  = 7'b0100000;
    localparam logic [6:0] O_B  = 7'b0010000;
    localparam logic [6:0] O_A  = 7'b0001000;
    localparam logic [6:0] O_FG = 7'b0000100;
    localparam logic [6:0] O_F  = 7'b0000010;
    localparam logic [6:0] O_U  = 7'b0000001;
    localparam logic [6:0] O_0  = 7'b0000000;

    logic clk = 1'b0;
    logic reset;
    logic left_sw, right_sw, brake_sw, hazard_btn, fog_btn;
    logic left, right, brake, alarm, fog, stalk_fault, cmd_upd;

    tail_cmd_conditioner #(.DEB_CYCLES(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .left_sw     (left_sw),
        .right_sw    (right_sw),
        .brake_sw    (brake_sw),
        .hazard_btn  (hazard_btn),
        .fog_btn     (fog_btn),
        .left        (left),
        .right       (right),
        .brake       (brake),
        .alarm       (alarm),
        .fog         (fog),
        .stalk_fault (stalk_fault),
        .cmd_upd     (cmd_upd)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int         cyc;
        logic [6:0] val;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %b want %b (l r b a fg flt upd)", tag, ecnt, obs, expv);
        end
    endtask

    // Queue an expectation dly edges from now (dly >= 1).
    task automatic expect_at(input int dly, input logic [6:0] v, input string tag);
        exp_t e;
        e.cyc = ecnt + dly;
        e.val = v;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == ecnt) begin
                chk(sb_q[i].tag,
                    {left, right, brake, alarm, fog, stalk_fault, cmd_upd},
                    sb_q[i].val);
                sb_q.delete(i);
            end else if (sb_q[i].cyc < ecnt) begin
                chk({sb_q[i].tag, "_missed"}, 7'bxxxxxxx, sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle reset; returns at the negedge right after the reset edge.
    task automatic do_reset();
        reset = 1'b1;
        expect_at(1, O_0, "reset_clear");
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        left_sw    = 1'b0;
        right_sw   = 1'b0;
        brake_sw   = 1'b0;
        hazard_btn = 1'b0;
        fog_btn    = 1'b0;
        cyc(2);
        do_reset();

        // Stalk qualification: left from edge 6, cmd_upd only at edge 6
        left_sw = 1'b1;
        expect_at(5, O_0, "left_pre");
        expect_at(6, O_L | O_U, "left_on");
        expect_at(7, O_L, "left_hold");
        cyc(10);

        // 2-cycle glitch rejected
        left_sw = 1'b0;
        expect_at(4, O_L, "glitch_a");
        expect_at(6, O_L, "glitch_b");
        expect_at(8, O_L, "glitch_c");
        cyc(2);
        left_sw = 1'b1;
        cyc(10);

        left_sw = 1'b0;
        expect_at(5, O_L, "left_off_pre");
        expect_at(6, O_U, "left_off");
        expect_at(7, O_0, "left_off_hold");
        cyc(10);

        // Stalk fault: both contacts, then drop right
        left_sw  = 1'b1;
        right_sw = 1'b1;
        expect_at(5, O_0, "fault_pre");
        expect_at(6, O_F, "fault_on");
        expect_at(8, O_F, "fault_hold");
        cyc(10);
        right_sw = 1'b0;
        expect_at(5, O_F, "fault_clr_pre");
        expect_at(6, O_L | O_U, "fault_clr");
        expect_at(7, O_L, "fault_clr_hold");
        cyc(10);
        left_sw = 1'b0;
        expect_at(6, O_U, "stalk_idle");
        expect_at(7, O_0, "stalk_idle_hold");
        cyc(10);

        // Hazard toggle: 4-cycle press sets, second clears, 2-cycle press ignored
        hazard_btn = 1'b1;
        expect_at(5, O_0, "haz1_pre");
        expect_at(6, O_A | O_U, "haz1_on");
        expect_at(7, O_A, "haz1_hold");
        expect_at(12, O_A, "haz1_after_rel");
        cyc(4);
        hazard_btn = 1'b0;
        cyc(12);
        hazard_btn = 1'b1;
        expect_at(5, O_A, "haz2_pre");
        expect_at(6, O_U, "haz2_off");
        expect_at(7, O_0, "haz2_hold");
        cyc(4);
        hazard_btn = 1'b0;
        cyc(12);
        hazard_btn = 1'b1;
        expect_at(6, O_0, "haz_short_a");
        expect_at(9, O_0, "haz_short_b");
        cyc(2);
        hazard_btn = 1'b0;
        cyc(12);

        // Arming: hazard held through reset never toggles
        hazard_btn = 1'b1;
        do_reset();
        expect_at(6, O_0, "arm_held_a");
        expect_at(8, O_0, "arm_held_b");
        expect_at(10, O_0, "arm_held_c");
        cyc(10);
        hazard_btn = 1'b0;
        cyc(8);
        hazard_btn = 1'b1;
        expect_at(5, O_0, "arm_press_pre");
        expect_at(6, O_A | O_U, "arm_press_on");
        cyc(4);
        hazard_btn = 1'b0;
        cyc(10);

        // Simultaneous fog + hazard + brake from a clean reset
        do_reset();
        cyc(4);
        fog_btn    = 1'b1;
        hazard_btn = 1'b1;
        brake_sw   = 1'b1;
        expect_at(5, O_0, "sim_pre");
        expect_at(6, O_B | O_A | O_FG | O_U, "sim_on");
        expect_at(7, O_B | O_A | O_FG, "sim_hold");
        cyc(4);
        fog_btn    = 1'b0;
        hazard_btn = 1'b0;
        expect_at(8, O_B | O_A | O_FG, "sim_after_rel");
        cyc(10);

        // Reset mid-operation with brake held
        do_reset();
        expect_at(5, O_0, "rst_mid_pre");
        expect_at(6, O_B | O_U, "rst_mid_brake");
        expect_at(7, O_B, "rst_mid_hold");
        expect_at(10, O_B, "rst_mid_latch0");
        cyc(12);
        brake_sw = 1'b0;
        cyc(10);

        // Every queued expectation must have been consumed
        n_chk++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Hard bound on simulation time
    initial begin
        #100000;
        $display("FAIL timeout: run did not complete, want completion");
        $fatal(1);
    end

endmodule
